// File: rtl/hilbert_framer.sv
// Ping-pong framer ahead of the 32-point Hilbert block. It collects the input
// stream into 32-sample frames and replays each one as a START-tagged burst, paced by HRDY.
module hilbert_framer #(
   parameter int total_bits = 32,
   parameter int FRAME      = 32,
   parameter int DRAIN_CYC  = 33,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [total_bits-1:0] DINReal,
   input  logic [total_bits-1:0] DINImag,
   output logic                  START,
   output logic                  ED,
   output logic [total_bits-1:0] DReal,
   output logic [total_bits-1:0] DImag,
   input  logic                  HRDY,
   output logic                  ERR,
   output logic [15:0]           FRAMES
);

   localparam int CW = $clog2(FRAME);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = 2 * total_bits;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DRAIN} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         mem_q [2*FRAME];
   logic [SW-1:0]         rd_word;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
   logic [1:0]            full_q, full_d;
   logic [DW-1:0]         dcnt_q, dcnt_d;
   logic [TW-1:0]         wcnt_q, wcnt_d;
   logic                  in_ready_q, in_ready_d;
   logic                  start_q, start_d;
   logic                  ed_q, ed_d;
   logic                  err_q, err_d;
   logic [total_bits-1:0] dreal_q, dreal_d;
   logic [total_bits-1:0] dimag_q, dimag_d;
   logic [15:0]           frames_q, frames_d;
   logic                  wr_en;
   logic                  rd_release;

   assign wr_en   = IN_VALID && in_ready_q;
   assign rd_word = mem_q[{rd_bank_q, rd_cnt_q}];

   // Sample storage carries no reset; the full flags decide what is valid.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[{wr_bank_q, wr_cnt_q}] <= {DINReal, DINImag};
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_bank_d  = rd_bank_q;
      rd_cnt_d   = rd_cnt_q;
      dcnt_d     = dcnt_q;
      wcnt_d     = wcnt_q;
      start_d    = 1'b0;
      ed_d       = 1'b1;
      err_d      = err_q;
      dreal_d    = dreal_q;
      dimag_d    = dimag_q;
      frames_d   = frames_q;
      rd_release = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = ST_SEND;
               rd_cnt_d = '0;
            end
         end
         ST_SEND: begin
            dreal_d  = rd_word[SW-1:total_bits];
            dimag_d  = rd_word[total_bits-1:0];
            start_d  = (rd_cnt_q == '0);
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (rd_cnt_q == CW'(FRAME - 1)) begin
               rd_release = 1'b1;
               rd_bank_d  = ~rd_bank_q;
               frames_d   = frames_q + 16'd1;
               wcnt_d     = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (HRDY) begin
               dcnt_d  = '0;
               state_d = ST_DRAIN;
            end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
               state_d = ST_IDLE;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The fill is applied after the release so a bank completed in the same cycle stays full.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_cnt_d  = wr_cnt_q;
      if (rd_release) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (wr_en) begin
         wr_cnt_d = wr_cnt_q + CW'(1);
         if (wr_cnt_q == CW'(FRAME - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end
      in_ready_d = !full_d[wr_bank_d];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         full_q     <= '0;
         dcnt_q     <= '0;
         wcnt_q     <= '0;
         in_ready_q <= 1'b0;
         start_q    <= 1'b0;
         ed_q       <= 1'b0;
         err_q      <= 1'b0;
         dreal_q    <= '0;
         dimag_q    <= '0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         full_q     <= full_d;
         dcnt_q     <= dcnt_d;
         wcnt_q     <= wcnt_d;
         in_ready_q <= in_ready_d;
         start_q    <= start_d;
         ed_q       <= ed_d;
         err_q      <= err_d;
         dreal_q    <= dreal_d;
         dimag_q    <= dimag_d;
         frames_q   <= frames_d;
      end
   end

   assign IN_READY = in_ready_q;
   assign START    = start_q;
   assign ED       = ed_q;
   assign DReal    = dreal_q;
   assign DImag    = dimag_q;
   assign ERR      = err_q;
   assign FRAMES   = frames_q;

endmodule

// File: tb/tb_hilbert_framer.sv
// Directed bench for hilbert_framer: a negedge monitor records every burst and can
// answer with an HRDY pulse a fixed number of cycles after the last sample of a burst.
module tb_hilbert_framer;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         IN_VALID = 1'b0;
   logic         IN_READY;
   logic [W-1:0] DINReal = '0;
   logic [W-1:0] DINImag = '0;
   logic         START;
   logic         ED;
   logic [W-1:0] DReal;
   logic [W-1:0] DImag;
   logic         HRDY;
   logic         ERR;
   logic [15:0]  FRAMES;

   logic         hrdy_man = 1'b0;
   logic         hrdy_auto = 1'b0;
   int           auto_h = 0;
   int           checks = 0;
   int           fails = 0;
   int           cyc = 0;
   int           start_q[$];
   logic [W-1:0] cap_re[$];
   logic [W-1:0] cap_im[$];
   int           bursts_done = 0;
   int           bidx = -1;
   int           rdy_cd = 0;

   assign HRDY = hrdy_man | hrdy_auto;

   hilbert_framer dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .DINReal(DINReal), .DINImag(DINImag), .START(START), .ED(ED),
      .DReal(DReal), .DImag(DImag), .HRDY(HRDY), .ERR(ERR), .FRAMES(FRAMES)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Burst capture; cyc at a negedge is the index of the edge that produced the sample.
   always @(negedge CLK) begin
      hrdy_auto = 1'b0;
      if (!RST_N) begin
         start_q.delete();
         cap_re.delete();
         cap_im.delete();
         bursts_done = 0;
         bidx = -1;
         rdy_cd = 0;
      end else begin
         if (rdy_cd > 0) begin
            rdy_cd--;
            if (rdy_cd == 0) hrdy_auto = 1'b1;
         end
         if (START) begin
            start_q.push_back(cyc);
            cap_re.push_back(DReal);
            cap_im.push_back(DImag);
            bidx = 0;
         end else if (bidx >= 0 && bidx < 31) begin
            bidx++;
            cap_re.push_back(DReal);
            cap_im.push_back(DImag);
            if (bidx == 31) begin
               bursts_done++;
               if (auto_h == 1) hrdy_auto = 1'b1;
               else if (auto_h > 1) rdy_cd = auto_h - 1;
            end
         end else begin
            bidx = -1;
         end
      end
   end

   task automatic do_reset();
      IN_VALID = 1'b0;
      hrdy_man = 1'b0;
      auto_h   = 0;
      @(negedge CLK);
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic wait_until_cyc(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im, output int acc_cyc);
      int n = 0;
      IN_VALID = 1'b1;
      DINReal  = re;
      DINImag  = im;
      while (!IN_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) begin
         checks++;
         fails++;
         $display("[TB] FAIL accept_timeout: IN_READY=%b after %0d cycles, required 1", IN_READY, n);
         acc_cyc = -1;
      end else begin
         @(negedge CLK);
         acc_cyc = cyc;
      end
   endtask

   task automatic send_frame(input logic [W-1:0] re0, input logic [W-1:0] im0, input bit gap,
                             output int last_acc);
      for (int k = 0; k < 32; k++) begin
         send_sample(re0 + 32'(k), im0 + 32'(k), last_acc);
         if (gap) begin
            IN_VALID = 1'b0;
            @(negedge CLK);
         end
      end
      IN_VALID = 1'b0;
   endtask

   task automatic wait_bursts(input int n, input int limit, input string name);
      int c = 0;
      while (bursts_done < n && c < limit) begin
         @(negedge CLK);
         c++;
      end
      checks++;
      if (bursts_done < n) begin
         fails++;
         $display("[TB] FAIL %s: %0d bursts seen, required %0d", name, bursts_done, n);
      end
   endtask

   task automatic check_burst(input int b, input logic [W-1:0] re0, input logic [W-1:0] im0,
                              input string name);
      int bad = -1;
      checks++;
      if (cap_re.size() < (b + 1) * 32) begin
         fails++;
         $display("[TB] FAIL %s: captured %0d samples, required %0d", name, cap_re.size(), (b + 1) * 32);
      end else begin
         for (int k = 0; k < 32; k++) begin
            if (bad < 0 && (cap_re[b*32+k] !== re0 + 32'(k) || cap_im[b*32+k] !== im0 + 32'(k))) bad = k;
         end
         if (bad >= 0) begin
            fails++;
            $display("[TB] FAIL %s: sample %0d got %0d/%0d, required %0d/%0d", name, bad,
                     cap_re[b*32+bad], cap_im[b*32+bad], re0 + 32'(bad), im0 + 32'(bad));
         end
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      checks++;
      if ({IN_READY, START, ED, ERR} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_flags: IN_READY/START/ED/ERR got %b, required 0000", {IN_READY, START, ED, ERR});
      end
      checks++;
      if (DReal !== '0 || DImag !== '0) begin
         fails++;
         $display("[TB] FAIL reset_data: got %0d/%0d, required 0/0", DReal, DImag);
      end
      checks++;
      if (FRAMES !== 16'd0) begin
         fails++;
         $display("[TB] FAIL reset_frames: got %0d, required 0", FRAMES);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if ({ED, IN_READY, START} !== 3'b110) begin
         fails++;
         $display("[TB] FAIL release_ed_ready: ED/IN_READY/START got %b, required 110", {ED, IN_READY, START});
      end
   endtask

   task automatic test_single_frame();
      int last;
      int s;
      int l;
      do_reset();
      send_frame(32'd0, 32'd100, 1'b0, last);
      wait_bursts(1, 100, "single_burst");
      s = (start_q.size() > 0) ? start_q[0] : -1;
      checks++;
      if (s != last + 2) begin
         fails++;
         $display("[TB] FAIL single_latency: START at edge %0d, required %0d", s, last + 2);
      end
      check_burst(0, 32'd0, 32'd100, "single_data");
      checks++;
      if (FRAMES !== 16'd1) begin
         fails++;
         $display("[TB] FAIL single_frames: got %0d, required 1", FRAMES);
      end
      l = last + 2 + 31;
      wait_until_cyc(l + 4090);
      checks++;
      if (ERR !== 1'b0) begin
         fails++;
         $display("[TB] FAIL single_err_early: ERR got %b, required 0", ERR);
      end
      wait_until_cyc(l + 4100);
      checks++;
      if (ERR !== 1'b1 || start_q.size() != 1) begin
         fails++;
         $display("[TB] FAIL single_timeout: ERR=%b starts=%0d, required ERR=1 starts=1", ERR, start_q.size());
      end
   endtask

   task automatic test_ping_pong();
      int acc;
      int h;
      int l2;
      int s;
      do_reset();
      for (int i = 0; i < 96; i++) begin
         send_sample(32'(1000 + i), 32'(2000 + i), acc);
         if (i == 63) begin
            checks++;
            if (IN_READY !== 1'b0) begin
               fails++;
               $display("[TB] FAIL pp_ready_after_64: got %b, required 0", IN_READY);
            end
         end
      end
      IN_VALID = 1'b0;
      repeat (20) @(negedge CLK);
      checks++;
      if (IN_READY !== 1'b0 || start_q.size() != 1) begin
         fails++;
         $display("[TB] FAIL pp_stall: IN_READY=%b starts=%0d, required 0 and 1", IN_READY, start_q.size());
      end
      check_burst(0, 32'd1000, 32'd2000, "pp_frame1_data");
      hrdy_man = 1'b1;
      h = cyc + 1;
      @(negedge CLK);
      hrdy_man = 1'b0;
      // 33 drain cycles, one IDLE cycle, then the registered START
      l2 = h + 35 + 31;
      wait_until_cyc(l2 - 1);
      checks++;
      if (IN_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL pp_ready_before_end: got %b, required 0", IN_READY);
      end
      wait_until_cyc(l2);
      checks++;
      if (IN_READY !== 1'b1) begin
         fails++;
         $display("[TB] FAIL pp_ready_at_end: got %b, required 1", IN_READY);
      end
      wait_bursts(2, 50, "pp_second_burst");
      s = (start_q.size() > 1) ? start_q[1] : -1;
      checks++;
      if (s != h + 35) begin
         fails++;
         $display("[TB] FAIL pp_start2_time: got edge %0d, required %0d", s, h + 35);
      end
      check_burst(1, 32'd1032, 32'd2032, "pp_frame2_data");
   endtask

   task automatic test_drain_guard();
      int acc;
      int gap;
      do_reset();
      auto_h = 10;
      for (int i = 0; i < 64; i++) send_sample(32'(5000 + i), 32'(6000 + i), acc);
      IN_VALID = 1'b0;
      wait_bursts(2, 400, "dg_bursts");
      gap = (start_q.size() > 1) ? start_q[1] - start_q[0] : -1;
      // 32 send + 10 until HRDY + 33 drain + 1 idle
      checks++;
      if (gap != 76) begin
         fails++;
         $display("[TB] FAIL dg_spacing: START-to-START %0d, required 76", gap);
      end
      check_burst(1, 32'd5032, 32'd6032, "dg_frame2_data");
      repeat (3) @(negedge CLK);
      checks++;
      if (FRAMES !== 16'd2) begin
         fails++;
         $display("[TB] FAIL dg_frames: got %0d, required 2", FRAMES);
      end
      auto_h = 0;
   endtask

   task automatic test_spurious_hrdy();
      int last;
      int h;
      int s;
      do_reset();
      hrdy_man = 1'b1;
      repeat (5) @(negedge CLK);
      hrdy_man = 1'b0;
      checks++;
      if (FRAMES !== 16'd0 || start_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL sp_idle: FRAMES=%0d starts=%0d, required 0 and 0", FRAMES, start_q.size());
      end
      send_frame(32'd7000, 32'd8000, 1'b0, last);
      wait_until_cyc(last + 3);
      hrdy_man = 1'b1;
      wait_until_cyc(last + 20);
      hrdy_man = 1'b0;
      wait_bursts(1, 100, "sp_burst");
      send_frame(32'd7032, 32'd8032, 1'b0, last);
      repeat (60) @(negedge CLK);
      checks++;
      if (FRAMES !== 16'd1 || start_q.size() != 1) begin
         fails++;
         $display("[TB] FAIL sp_send_ignored: FRAMES=%0d starts=%0d, required 1 and 1", FRAMES, start_q.size());
      end
      hrdy_man = 1'b1;
      h = cyc + 1;
      @(negedge CLK);
      hrdy_man = 1'b0;
      wait_bursts(2, 100, "sp_second_burst");
      s = (start_q.size() > 1) ? start_q[1] : -1;
      checks++;
      if (s != h + 35) begin
         fails++;
         $display("[TB] FAIL sp_start2_time: got edge %0d, required %0d", s, h + 35);
      end
      check_burst(1, 32'd7032, 32'd8032, "sp_frame2_data");
   endtask

   task automatic test_gapped();
      int last;
      do_reset();
      auto_h = 5;
      send_frame(32'd3000, 32'd4000, 1'b1, last);
      send_frame(32'd3032, 32'd4032, 1'b1, last);
      wait_bursts(2, 600, "gap_bursts");
      repeat (5) @(negedge CLK);
      checks++;
      if (start_q.size() != 2 || cap_re.size() != 64) begin
         fails++;
         $display("[TB] FAIL gap_counts: starts=%0d samples=%0d, required 2 and 64", start_q.size(), cap_re.size());
      end
      check_burst(0, 32'd3000, 32'd4000, "gap_frame1_data");
      check_burst(1, 32'd3032, 32'd4032, "gap_frame2_data");
      auto_h = 0;
   endtask

   task automatic test_mid_reset();
      int last;
      int s;
      do_reset();
      send_frame(32'd500, 32'd900, 1'b0, last);
      wait_until_cyc(last + 2 + 12);
      checks++;
      if (DReal !== 32'd512) begin
         fails++;
         $display("[TB] FAIL mr_sample12: got %0d, required 512", DReal);
      end
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({START, ED, IN_READY} !== 3'b000 || DReal !== '0 || FRAMES !== 16'd0) begin
         fails++;
         $display("[TB] FAIL mr_async: START/ED/IN_READY=%b DReal=%0d FRAMES=%0d, required 000/0/0",
                  {START, ED, IN_READY}, DReal, FRAMES);
      end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (40) @(negedge CLK);
      checks++;
      if (start_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL mr_no_reissue: starts=%0d, required 0", start_q.size());
      end
      send_frame(32'd600, 32'd1100, 1'b0, last);
      wait_bursts(1, 100, "mr_fresh_burst");
      s = (start_q.size() > 0) ? start_q[0] : -1;
      checks++;
      if (s != last + 2 || FRAMES !== 16'd1) begin
         fails++;
         $display("[TB] FAIL mr_fresh: START edge %0d FRAMES=%0d, required %0d and 1", s, FRAMES, last + 2);
      end
      check_burst(0, 32'd600, 32'd1100, "mr_fresh_data");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_ping_pong();
      test_drain_guard();
      test_spurious_hrdy();
      test_gapped();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/hilbert_framer.md
Name: hilbert_framer

Overview:
Upstream framing stage for the 32-point Hilbert block. It accepts a continuous complex sample stream through a valid/ready handshake and collects it into 32-sample frames in a ping-pong buffer. Each complete frame is replayed as one START-tagged 32-cycle burst with ED held high. A new burst is not issued until the Hilbert block has signalled RDY and finished draining its output frame, so a START never aborts a frame still in progress.

Parameters:
total_bits, 32, sample width of each real/imag component (two's complement)
FRAME, 32, samples per frame; fixed to the transform length
DRAIN_CYC, 33, cycles to wait after a downstream RDY pulse before the next START
TIMEOUT, 4096, max cycles to wait for downstream RDY after a burst

Ports:
CLK  in  1  clock, all logic on posedge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  input sample valid
IN_READY  out  1  framer can accept a sample this cycle
DINReal  in  total_bits  input sample, real part
DINImag  in  total_bits  input sample, imag part
START  out  1  one-cycle pulse, coincident with sample 0 of a burst
ED  out  1  downstream enable
DReal  out  total_bits  burst sample to the Hilbert block, real part
DImag  out  total_bits  burst sample to the Hilbert block, imag part
HRDY  in  1  RDY pulse from the Hilbert block
ERR  out  1  sticky timeout flag
FRAMES  out  16  count of bursts issued, wraps at 65535

Behaviour:
- Reset (async, RST_N=0):
  - Outputs: IN_READY=0, START=0, ED=0, DReal=0, DImag=0, ERR=0, FRAMES=0.
  - Internal: both bank-full flags cleared, write bank=0, write count=0, state=IDLE.
  - Any partial or stored frame is discarded.
- Reset release: ED=1 from the first clock edge after RST_N rises, and stays high until the next reset.
- Write side:
  - A sample is accepted when IN_VALID & IN_READY; it is written to wr_bank[wr_cnt] and wr_cnt increments.
  - On the 32nd accept, full[wr_bank] is set, wr_cnt wraps to 0 and wr_bank toggles.
  - IN_READY = !full[wr_bank] (registered). It deasserts when both banks are full.
- Read-side FSM:
  - IDLE: if full[rd_bank] -> SEND and rd_cnt=0.
  - SEND: on each cycle, DReal/DImag <= bank[rd_bank][rd_cnt], and START=1 only when rd_cnt==0. After rd_cnt==31: clear full[rd_bank], toggle rd_bank, increment FRAMES, go to WAIT.
  - WAIT: when HRDY=1 -> DRAIN with dcnt=0. If TIMEOUT cycles pass without HRDY: set ERR and go to IDLE.
  - DRAIN: dcnt increments; at dcnt==DRAIN_CYC-1 -> IDLE.
- HRDY outside WAIT is ignored.
- Burst timing:
  - Outputs are registered. START and sample 0 appear in the same cycle.
  - Samples 1..31 follow on 31 consecutive cycles with no gaps.
  - In every cycle outside SEND, DReal/DImag hold their last value and START=0.
- Latency: if the read side is idle, START appears 2 cycles after the accept edge of the 32nd sample of a frame.
- Simultaneous events:
  - A read-side release of a bank and a write-side fill of the other bank in the same cycle are both honoured.
  - If the write side completes the bank being released in that same cycle (possible only through the toggle), full is set, not cleared: the write wins for its own bank.
  - Frame order is strictly FIFO; frames are never dropped or reordered.
- Back-to-back issue: minimum START-to-START spacing = 32 (SEND) + Hilbert latency to RDY + DRAIN_CYC + 1 (IDLE).
- Reset mid-burst: outputs return to reset values asynchronously. A burst in flight is abandoned and is not reissued.

Test Plan:
- Single frame: stream samples k+j*(100+k) for k=0..31 with IN_VALID=1 and HRDY never asserted -> START once, 2 cycles after the last accept; DReal=0..31 on consecutive cycles; FRAMES=1; ERR=1 after 4096 cycles.
- Ping-pong stall: push 96 samples continuously while a model holds HRDY low -> IN_READY falls after sample 64. Pulse HRDY -> after 33 drain cycles, frame 2 bursts and IN_READY rises within 1 cycle of frame 2 finishing.
- Drain guard: pulse HRDY 10 cycles after a burst while a second frame is full -> the next START comes exactly 10+33+1 cycles later, never earlier.
- Spurious HRDY: assert HRDY during SEND and IDLE -> no state change, no extra START, FRAMES unchanged.
- Gapped input: IN_VALID toggles 1010... for 64 accepts -> two bursts, each 32 contiguous cycles, data in order, with no duplicated or missing samples.
- Mid-burst reset: drop RST_N at burst sample 12 -> START/ED/DReal/IN_READY go to 0 immediately. After release, a fresh 32-sample frame produces a correct burst and FRAMES=1.
